usb_tx: RTL and testbench
=========================

# usb_tx

FT245-style host-write transmitter. Sends bytes from the FPGA back to the USB host: generator status, readback of frequency, amplitude and phase state, and command acknowledgements. It sits beside the command receiver in the top level and shares the 8-bit `d` bus with it through a request/grant arbiter. It also drives the chip's `wr` and `SI` pins. An internal byte FIFO decouples producers from host back-pressure signalled on `txe`.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in bytes; power of two, ≥2.
- `T_SETUP`, 2: clk cycles that data is driven before `wr` rises.
- `T_WR_HIGH`, 3: clk cycles that `wr` is held high (≥50 ns at 50 MHz).
- `T_RECOVER`, 3: clk cycles after `wr` falls during which `txe` is ignored.
- `SI_CYCLES`, 3: width of the `SI` low pulse.

Ports:
- `clk`  in  1: system clock. One clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `in_data`  in  8: byte to send.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: FIFO not full. A byte is accepted on a cycle where `in_valid` and `in_ready` are both high.
- `flush`  in  1: one-cycle pulse requesting send-immediate.
- `txe`  in  1: FT245 TXE#, active low, asynchronous to `clk`.
- `bus_req`  out  1: request ownership of `d`.
- `bus_gnt`  in  1: arbiter grant.
- `wr`  out  1: FT245 WR strobe. Active high; the chip latches data on the falling edge.
- `d_out`  out  8: data for the `d` pads.
- `d_oe`  out  1: tristate enable for `d`.
- `SI`  out  1: send-immediate/wake-up, active low.

## Operation
- `txe` passes through a 2-flop synchronizer to give `txe_s`.
- The FIFO is a circular buffer.
  - `in_ready = !full`.
  - A push and a pop may occur in the same cycle.
  - No push is possible while the FIFO is full.
- State machine:
  - IDLE: if the FIFO is not empty and `txe_s`=0, go to REQ. Otherwise, if flush is pending and the FIFO is empty, go to SI_PULSE.
  - REQ: `bus_req`=1.
    - If `txe_s`=1, return to IDLE with `bus_req`=0.
    - If `bus_gnt`=1 and `txe_s`=0, go to SETUP.
  - SETUP: `d_oe`=1, `d_out`=FIFO head. Stay `T_SETUP` cycles, then go to STROBE.
  - STROBE: `wr`=1, data held. Stay `T_WR_HIGH` cycles, then go to HOLD.
  - HOLD: 1 cycle. `wr`=0, data still driven. Pop the FIFO head in this cycle, then go to RECOVER.
  - RECOVER: `d_oe`=0, `bus_req`=1. Stay `T_RECOVER` cycles, then go to IDLE. IDLE always drops `bus_req` for at least one cycle between bytes so the receiver can win arbitration.
  - SI_PULSE: `SI`=0 for `SI_CYCLES` cycles, then clear the pending flag and return to IDLE.
- Flush behaviour:
  - `flush` sets a sticky pending flag, even while the FIFO is non-empty.
  - The SI pulse is issued only after every byte already queued has been written.
  - A `flush` arriving while the flag is already set is absorbed: only one pulse results.
- `bus_req` stays high continuously from REQ through RECOVER. The arbiter must not revoke `bus_gnt` while `bus_req` is high; `bus_gnt` is ignored outside REQ.
- A byte leaves the FIFO only after its complete `wr` pulse.

## Timing
- Reset values: `wr`=0, `d_oe`=0, `d_out`=0, `SI`=1, `bus_req`=0, `in_ready`=1. FIFO is empty, flush flag is clear, state is IDLE.
- Latency: with the FIFO empty, `txe_s`=0 stable and `bus_gnt` returned in the same cycle as `bus_req`:
  - push at edge N: `bus_req` rises at N+2, `d_oe` at N+3, `wr` at N+3+`T_SETUP`.
- One byte occupies 1+1+`T_SETUP`+`T_WR_HIGH`+1+`T_RECOVER` = 11 cycles minimum at default parameters.
- Mid-operation `rst`: all outputs return to reset values immediately (asynchronously), the FIFO is cleared and a truncated strobe is abandoned. Bytes in flight are lost; this is accepted.
- `txe` rising after SETUP does not abort the current byte.

## Structure
- Package `usb_pkg`:
  - state enum `tx_state_t` (IDLE, REQ, SETUP, STROBE, HOLD, RECOVER, SI_PULSE);
  - default timing constants, shared with the receiver;
  - byte width 8.
- Sub-module `usb_tx_fifo`: parameterized synchronous FIFO with push/pop/full/empty and async reset.
- A single timing counter is shared across the states, sized for the largest timing parameter.

## Test plan
- Single byte: push 0xA5 with `txe`=0 and `bus_gnt` tied to `bus_req` → `d_out`=0xA5 with `d_oe`=1 two cycles before `wr` rises; `wr` high exactly 3 cycles; `d_oe` falls 1 cycle after `wr` falls.
- Burst/full: push 0x00..0x09 back-to-back → `in_ready` is low after 8 accepted; all 10 bytes appear on `d_out` in order; `bus_req` goes low ≥1 cycle between bytes.
- Back-pressure: `txe`=1 while 3 bytes are queued → no `bus_req` and no `wr`. Release `txe` → 3 writes. Raise `txe` mid-STROBE → that byte completes, and the next waits.
- Flush: push 0x11, 0x22, 0x33 then pulse `flush` twice → 3 writes, then one `SI` low pulse of exactly 3 cycles after the last RECOVER.
- Grant delay: hold `bus_gnt`=0 for 20 cycles → `bus_req` held and `d_oe`=0 throughout; the write proceeds once grant is given.
- Reset mid-strobe: assert `rst` during STROBE → `wr`, `d_oe` and `bus_req` go to 0 and `SI` to 1 without waiting for a clock edge; after release, the FIFO is empty and `in_ready`=1.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB FT245 interface types and default timing.
// Used by the host-write transmitter and the command receiver.
package usb_pkg;

  localparam int BYTE_W = 8;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_T_SETUP   = 2;
  localparam int DEF_T_WR_HIGH = 3;
  localparam int DEF_T_RECOVER = 3;
  localparam int DEF_SI_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    STROBE,
    HOLD,
    RECOVER,
    SI_PULSE
  } tx_state_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// Circular byte FIFO for the FT245 transmitter.
// Head is shown ahead; pop only advances the read pointer.
module usb_tx_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = BYTE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer bit tells full from empty when indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign head = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/usb_tx.sv
// FT245 host-write transmitter: FIFO, bus arbitration,
// WR strobe timing and send-immediate (SI) pulse.
module usb_tx
  import usb_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_WR_HIGH = DEF_T_WR_HIGH,
  parameter int T_RECOVER = DEF_T_RECOVER,
  parameter int SI_CYCLES = DEF_SI_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              txe,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              wr,
  output logic [BYTE_W-1:0] d_out,
  output logic              d_oe,
  output logic              SI
);

  localparam int CMAX = max2(max2(T_SETUP, T_WR_HIGH),
                             max2(T_RECOVER, SI_CYCLES));
  localparam int CW = $clog2(CMAX + 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [CW-1:0]     cnt;
  logic              cnt_done;
  logic              txe_m;
  logic              txe_s;
  logic              avail;
  logic              pending;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [BYTE_W-1:0] head;

  assign in_ready = ~fifo_full;
  assign pop      = (state == HOLD);

  usb_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TXE# resets to "not ready" until the chip is actually seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= txe;
      txe_s <= txe_m;
    end
  end

  // Registered occupancy gives the push-to-request latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail   <= 1'b0;
      pending <= 1'b0;
    end else begin
      avail   <= ~fifo_empty;
      pending <= flush |
                 (pending & ~(state == SI_PULSE && cnt_done));
    end
  end

  always_comb begin
    cnt_done = 1'b0;
    case (state)
      SETUP:    cnt_done = (cnt == CW'(T_SETUP - 1));
      STROBE:   cnt_done = (cnt == CW'(T_WR_HIGH - 1));
      RECOVER:  cnt_done = (cnt == CW'(T_RECOVER - 1));
      SI_PULSE: cnt_done = (cnt == CW'(SI_CYCLES - 1));
      default:  cnt_done = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (avail && !txe_s)
          state_next = REQ;
        else if (pending && fifo_empty && !avail)
          state_next = SI_PULSE;
      end
      REQ: begin
        if (txe_s)        state_next = IDLE;
        else if (bus_gnt) state_next = SETUP;
      end
      SETUP:    if (cnt_done) state_next = STROBE;
      STROBE:   if (cnt_done) state_next = HOLD;
      HOLD:     state_next = RECOVER;
      RECOVER:  if (cnt_done) state_next = IDLE;
      SI_PULSE: if (cnt_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
    end
  end

  // Pin outputs are registered from the next state to stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req <= 1'b0;
      d_oe    <= 1'b0;
      wr      <= 1'b0;
      d_out   <= '0;
      SI      <= 1'b1;
    end else begin
      bus_req <= state_next inside {REQ, SETUP, STROBE, HOLD, RECOVER};
      d_oe    <= state_next inside {SETUP, STROBE, HOLD};
      wr      <= (state_next == STROBE);
      d_out   <= (state_next inside {SETUP, STROBE, HOLD}) ? head : '0;
      SI      <= (state_next != SI_PULSE);
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx.
// Reference model tracks FIFO occupancy and byte order.
module tb_usb_tx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       txe = 1'b0;
  logic       bus_req;
  logic       bus_gnt;
  logic       wr;
  logic [7:0] d_out;
  logic       d_oe;
  logic       SI;

  logic gnt_mode = 1'b1;
  logic gnt_force = 1'b0;
  assign bus_gnt = gnt_mode ? bus_req : gnt_force;

  usb_tx dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .txe      (txe),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .wr       (wr),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .SI       (SI)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int occ = 0;
  bit push_pend = 0;
  bit pop_pend = 0;
  logic prev_wr = 0, prev_si = 1, prev_req = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int rdy_bad = 0, req_rises = 0, si_pulses = 0;
  int si_w = 0, si_cur = 0, cyc = 0;
  int wrfall_cyc = 0, sifall_cyc = 0;

  // Model: a byte enters on valid with room, leaves the cycle after WR falls.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      occ = 0; push_pend = 0; pop_pend = 0;
      exp_q.delete();
      prev_wr = 0; prev_si = 1; prev_req = 0; si_cur = 0;
    end else begin
      occ = occ + int'(push_pend) - int'(pop_pend);
      push_pend = 0; pop_pend = 0;
      if (in_ready !== (occ < DEPTH)) rdy_bad++;
      if (in_valid && occ < DEPTH) begin
        push_pend = 1;
        exp_q.push_back(in_data);
      end
      if (prev_wr && !wr) begin
        pop_pend = 1;
        wrfall_cyc = cyc;
      end
      if (!prev_wr && wr) got_q.push_back(d_out);
      if (!prev_req && bus_req) req_rises++;
      if (!SI) si_cur++;
      if (prev_si && !SI) sifall_cyc = cyc;
      if (!prev_si && SI) begin
        si_pulses++; si_w = si_cur; si_cur = 0;
      end
      prev_wr = wr; prev_si = SI; prev_req = bus_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int c;
    for (c = 0; c < 300; c++) begin
      if (!bus_req && SI && occ == 0 && !push_pend) break;
      tick();
    end
    if (c == 300) begin
      n_err++;
      $display("FAIL quiet_timeout: bus_req=%b occ=%0d", bus_req, occ);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [12:0] got;
    #1 rst = 1'b1;
    #1;
    got = {wr, d_oe, d_out, SI, bus_req, in_ready};
    n_vec++;
    if (got !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000000101", got);
    end
    repeat (3) tick();
    rst = 1'b0;
    txe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    int t_req = -1, t_oe = -1, t_wr = -1, t_wrf = -1, t_oef = -1;
    int wr_n = 0, d_bad = 0;
    logic [7:0] d_wr = '0;
    wait_quiet();
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus_req && t_req < 0) t_req = c;
      if (d_oe && t_oe < 0) t_oe = c;
      if (wr && t_wr < 0) begin t_wr = c; d_wr = d_out; end
      if (wr) wr_n++;
      if (!wr && t_wr >= 0 && t_wrf < 0) t_wrf = c;
      if (!d_oe && t_oe >= 0 && t_oef < 0) t_oef = c;
      if (d_oe && d_out !== 8'hA5) d_bad++;
    end
    n_vec++;
    if (t_req != 2) begin n_err++;
      $display("FAIL single_req_lat: got %0d want 2", t_req); end
    n_vec++;
    if (t_oe != 3) begin n_err++;
      $display("FAIL single_oe_lat: got %0d want 3", t_oe); end
    n_vec++;
    if (t_wr != 5) begin n_err++;
      $display("FAIL single_wr_lat: got %0d want 5", t_wr); end
    n_vec++;
    if (wr_n != 3) begin n_err++;
      $display("FAIL single_wr_width: got %0d want 3", wr_n); end
    n_vec++;
    if (t_oef != t_wrf + 1 || t_wrf < 0) begin n_err++;
      $display("FAIL single_oe_fall: got %0d want %0d", t_oef, t_wrf + 1); end
    n_vec++;
    if (d_wr !== 8'hA5 || d_bad != 0) begin n_err++;
      $display("FAIL single_data: got %h (bad %0d) want a5", d_wr, d_bad); end
  endtask

  task automatic test_burst();
    int i = 0;
    logic acc;
    wait_quiet();
    txe = 1'b1;
    repeat (4) tick();
    got_q.delete();
    req_rises = 0;
    in_data = 8'h00;
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); acc = in_ready;
      tick();
      if (acc) begin i++; in_data = 8'(i); end
    end
    n_vec++;
    if (i != 8 || in_ready !== 1'b0) begin n_err++;
      $display("FAIL burst_full: accepted %0d ready %b want 8 0", i, in_ready); end
    txe = 1'b0;
    for (int c = 0; c < 200 && i < 10; c++) begin
      @(negedge clk); acc = in_ready;
      tick();
      if (acc) begin
        i++; in_data = 8'(i);
        if (i == 10) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 300 && (got_q.size() < 10 || bus_req); c++) tick();
    n_vec++;
    if (got_q.size() != 10) begin n_err++;
      $display("FAIL burst_count: got %0d want 10", got_q.size()); end
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      n_vec++;
      if (got_q[k] !== 8'(k)) begin n_err++;
        $display("FAIL burst_byte%0d: got %h want %h", k, got_q[k], 8'(k)); end
    end
    n_vec++;
    if (req_rises != 10) begin n_err++;
      $display("FAIL burst_req_gaps: got %0d want 10", req_rises); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [5];
    bit seen = 0;
    wait_quiet();
    txe = 1'b1;
    repeat (4) tick();
    got_q.delete();
    for (int k = 0; k < 5; k++) b[k] = 8'($urandom);
    for (int k = 0; k < 3; k++) push_byte(b[k]);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus_req || wr) seen = 1;
    end
    n_vec++;
    if (seen) begin n_err++;
      $display("FAIL bp_blocked: got activity want none"); end
    txe = 1'b0;
    for (int c = 0; c < 100 && got_q.size() < 3; c++) tick();
    push_byte(b[3]);
    push_byte(b[4]);
    for (int c = 0; c < 100 && got_q.size() < 4; c++) tick();
    txe = 1'b1;
    for (int c = 0; c < 20 && (wr || got_q.size() < 4); c++) tick();
    repeat (8) tick();
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus_req || wr) seen = 1;
    end
    n_vec++;
    if (seen || got_q.size() != 4) begin n_err++;
      $display("FAIL bp_mid_strobe: got %0d writes want 4 and idle", got_q.size()); end
    txe = 1'b0;
    for (int c = 0; c < 100 && got_q.size() < 5; c++) tick();
    n_vec++;
    if (got_q.size() != 5) begin n_err++;
      $display("FAIL bp_count: got %0d want 5", got_q.size()); end
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      n_vec++;
      if (got_q[k] !== b[k]) begin n_err++;
        $display("FAIL bp_byte%0d: got %h want %h", k, got_q[k], b[k]); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] b [3];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    wait_quiet();
    got_q.delete();
    si_pulses = 0;
    for (int k = 0; k < 3; k++) push_byte(b[k]);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int c = 0; c < 200 && si_pulses < 1; c++) tick();
    repeat (20) tick();
    n_vec++;
    if (got_q.size() != 3) begin n_err++;
      $display("FAIL flush_count: got %0d want 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      n_vec++;
      if (got_q[k] !== b[k]) begin n_err++;
        $display("FAIL flush_byte%0d: got %h want %h", k, got_q[k], b[k]); end
    end
    n_vec++;
    if (si_pulses != 1) begin n_err++;
      $display("FAIL flush_pulses: got %0d want 1", si_pulses); end
    n_vec++;
    if (si_w != 3) begin n_err++;
      $display("FAIL flush_si_width: got %0d want 3", si_w); end
    n_vec++;
    if (sifall_cyc - wrfall_cyc != 5) begin n_err++;
      $display("FAIL flush_si_delay: got %0d want 5", sifall_cyc - wrfall_cyc); end
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (15) tick();
    n_vec++;
    if (si_pulses != 2 || si_w != 3) begin n_err++;
      $display("FAIL flush_empty: got %0d pulses width %0d want 2 3", si_pulses, si_w); end
  endtask

  task automatic test_grant();
    logic [7:0] b;
    bit bad = 0;
    wait_quiet();
    got_q.delete();
    gnt_mode = 1'b0;
    gnt_force = 1'b0;
    b = 8'($urandom);
    push_byte(b);
    for (int c = 0; c < 20 && !bus_req; c++) tick();
    for (int c = 0; c < 20; c++) begin
      if (!bus_req || d_oe || wr) bad = 1;
      tick();
    end
    n_vec++;
    if (bad) begin n_err++;
      $display("FAIL grant_hold: got req/oe violation want req=1 oe=0"); end
    gnt_force = 1'b1;
    for (int c = 0; c < 30 && got_q.size() < 1; c++) tick();
    for (int c = 0; c < 30 && bus_req; c++) tick();
    gnt_mode = 1'b1;
    gnt_force = 1'b0;
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== b) begin n_err++;
      $display("FAIL grant_write: got %0d writes want 1 of %h", got_q.size(), b); end
  endtask

  task automatic test_reset_mid();
    logic [12:0] got;
    bit seen = 0;
    wait_quiet();
    push_byte(8'h5A);
    push_byte(8'hC3);
    for (int c = 0; c < 30 && !wr; c++) tick();
    #1 rst = 1'b1;
    #1;
    got = {wr, d_oe, d_out, SI, bus_req, in_ready};
    n_vec++;
    if (got !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1}) begin n_err++;
      $display("FAIL rstmid_outputs: got %b want 0000000000101", got); end
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus_req || wr) seen = 1;
    end
    n_vec++;
    if (seen || in_ready !== 1'b1) begin n_err++;
      $display("FAIL rstmid_empty: got ready %b activity %0d want 1 0", in_ready, seen); end
  endtask

  task automatic test_random();
    wait_quiet();
    got_q.delete();
    exp_q.delete();
    rdy_bad = 0;
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = 8'($urandom);
      if ($urandom_range(0, 19) == 0) txe = ~txe;
      tick();
    end
    in_valid = 1'b0;
    txe = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (occ == 0 && !push_pend && !bus_req &&
          got_q.size() == exp_q.size()) break;
      tick();
    end
    n_vec++;
    if (got_q.size() != exp_q.size() || got_q.size() < 20) begin n_err++;
      $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_vec++;
      if (got_q[k] !== exp_q[k]) begin n_err++;
        $display("FAIL rand_byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
    n_vec++;
    if (rdy_bad != 0) begin n_err++;
      $display("FAIL rand_in_ready: got %0d cycles wrong want 0", rdy_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_flush();
    test_grant();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
